// File: rtl/tx_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tx_byte_serializer
// Function : Byte serializer. Each frame is a start bit, DATA_W data bits
//            (LSB first) and a stop bit. A one-entry holding register lets
//            the next byte wait while the current one shifts, so frames can
//            run back to back.
// Options  : TX_PARITY_EN inserts an even-parity bit between data and stop.
// Revision : 1.0 - initial release
// ============================================================================
module tx_byte_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic              ready,
  output logic              busy,
  output logic              serial_out,
  output logic              done,
  output logic              overrun
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W) + 1;

  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_STOP   = 3'd4;
`ifdef TX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif

  logic [2:0]        state_q,      state_d;
  logic [BAUD_W-1:0] baud_cnt_q,   baud_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [DATA_W-1:0] shift_q,      shift_d;
  logic [DATA_W-1:0] hold_q,       hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              ready_q,      ready_d;
  logic              busy_q,       busy_d;
  logic              serial_q,     serial_d;
  logic              done_q,       done_d;
  logic              overrun_q,    overrun_d;
`ifdef TX_PARITY_EN
  logic              parity_q,     parity_d;
`endif

  logic w_bit_end;

  assign w_bit_end = (baud_cnt_q == c_BAUD_LAST);

  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
`ifdef TX_PARITY_EN
    parity_d     = parity_q;
`endif

    // A write into a full holding register is dropped; a new overrun beats clr_err.
    if (load && ready_q) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end else if (load && !ready_q) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      c_ST_IDLE: begin
        baud_cnt_d = '0;
        if (hold_valid_q) begin
          state_d      = c_ST_START;
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          bit_cnt_d    = '0;
`ifdef TX_PARITY_EN
          parity_d     = ^hold_q;
`endif
        end
      end

      c_ST_START: begin
        if (w_bit_end) begin
          state_d    = c_ST_DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      c_ST_DATA: begin
        if (w_bit_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == c_BIT_LAST) begin
`ifdef TX_PARITY_EN
            state_d = c_ST_PARITY;
`else
            state_d = c_ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

`ifdef TX_PARITY_EN
      c_ST_PARITY: begin
        if (w_bit_end) begin
          state_d    = c_ST_STOP;
          baud_cnt_d = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
`endif

      c_ST_STOP: begin
        if (w_bit_end) begin
          done_d     = 1'b1;
          baud_cnt_d = '0;
          // A waiting byte starts its start bit right away, with no idle gap.
          if (hold_valid_q) begin
            state_d      = c_ST_START;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = '0;
`ifdef TX_PARITY_EN
            parity_d     = ^hold_q;
`endif
          end else begin
            state_d = c_ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = c_ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // Line level is derived from the next state so it lines up with busy and done.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      c_ST_START:  serial_d = 1'b0;
      c_ST_DATA:   serial_d = shift_d[0];
`ifdef TX_PARITY_EN
      c_ST_PARITY: serial_d = parity_d;
`endif
      default:     serial_d = 1'b1;
    endcase
  end

  assign ready_d = ~hold_valid_d;
  assign busy_d  = (state_d != c_ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_ST_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      serial_q     <= 1'b1;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      serial_q     <= serial_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
`ifdef TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign serial_out = serial_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_byte_serializer
// Function : Bench for tx_byte_serializer (CLKS_PER_BIT=4, DATA_W=8). Bytes
//            are queued on load; a line monitor decodes frames and checks
//            each one against the queue when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_byte_serializer;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          clr_err = 1'b0;
  logic          ready, busy, serial_out, done, overrun;

  tx_byte_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .clr_err    (clr_err),
    .ready      (ready),
    .busy       (busy),
    .serial_out (serial_out),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: collects FRAME samples per frame, then expects done next cycle.
  logic [FRAME-1:0] fb;
  int               cyc = 0;
  bit               in_frame = 1'b0;
  bit               expect_done = 1'b0;
  logic [DW-1:0]    rx, exp_b;
  bit               shape_ok;

  always @(negedge clk) begin
    if (rst) begin
      in_frame    = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        expect_done = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        shape_ok = 1'b1;
        for (int b = 0; b < NBITS; b++)
          for (int k = 1; k < CPB; k++)
            if (fb[b*CPB+k] !== fb[b*CPB]) shape_ok = 1'b0;
        if (fb[0] !== 1'b0) shape_ok = 1'b0;
        if (fb[(NBITS-1)*CPB] !== 1'b1) shape_ok = 1'b0;
        for (int i = 0; i < DW; i++) rx[i] = fb[(i+1)*CPB];
        chk("frame_shape", {31'd0, shape_ok}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          chk("frame_data", {24'd0, rx}, {24'd0, exp_b});
`ifdef TX_PARITY_EN
          chk("parity_bit", {31'd0, fb[(DW+1)*CPB]}, {31'd0, ^exp_b});
`endif
          frames++;
        end
      end else if (done === 1'b1) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end

      if (in_frame && busy !== 1'b1) begin
        in_frame = 1'b0;
      end else if (!in_frame && serial_out === 1'b0) begin
        in_frame = 1'b1;
        cyc      = 0;
      end
      if (in_frame) begin
        fb[cyc] = serial_out;
        cyc++;
        if (cyc == FRAME) begin
          in_frame    = 1'b0;
          expect_done = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] b);
    wait_ready();
    load    = 1'b1;
    data_in = b;
    exp_q.push_back(b);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || ready !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready",   {31'd0, ready},      32'd1);
    chk("rst_busy",    {31'd0, busy},       32'd0);
    chk("rst_serial",  {31'd0, serial_out}, 32'd1);
    chk("rst_done",    {31'd0, done},       32'd0);
    chk("rst_overrun", {31'd0, overrun},    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: start bit appears on the second edge after load.
    send(8'hAA);
    chk("hold_ready",   {31'd0, ready},      32'd0);
    chk("pre_start",    {31'd0, serial_out}, 32'd1);
    chk("pre_busy",     {31'd0, busy},       32'd0);
    @(negedge clk);
    chk("start_bit",    {31'd0, serial_out}, 32'd0);
    chk("start_busy",   {31'd0, busy},       32'd1);
    chk("ready_return", {31'd0, ready},      32'd1);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    chk("busy_len", n, FRAME);
    repeat (2) @(negedge clk);
    chk("frames_after_single", frames, 1);

    // Back-to-back: second done exactly one frame after the first.
    send(8'hAA);
    send(8'hBB);
    wait_done();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 200);
    chk("b2b_done_gap", n, FRAME);
    wait_idle();

    // Overrun: third byte dropped, set beats clear, clear works alone.
    send(8'hAA);
    send(8'hBB);
    chk("full_ready", {31'd0, ready}, 32'd0);
    load    = 1'b1;
    data_in = 8'hCC;
    @(negedge clk);
    load = 1'b0;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    load    = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    clr_err = 1'b0;
    chk("overrun_set_wins", {31'd0, overrun}, 32'd1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    wait_idle();

    // Reset during data bit 3 of 0x55 aborts the frame with no done.
    send(8'h55);
    repeat (18) @(negedge clk);
    chk("mid_frame_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_serial", {31'd0, serial_out}, 32'd1);
    chk("abort_busy",   {31'd0, busy},       32'd0);
    chk("abort_ready",  {31'd0, ready},      32'd1);
    chk("abort_done",   {31'd0, done},       32'd0);
    repeat (5) @(negedge clk);
    send(8'h0F);
    wait_idle();

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("frames_sent", frames, 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
